seq_bnn_ctrl: RTL and testbench

- Sequencing controller for the sequential BNN datapath. It accepts one feature vector per inference over a valid/ready handshake and latches it.
- It steps the datapath through layer 0 one hidden neuron per cycle, then through layer 1 one class score per cycle.
- It tracks the argmax of the class scores and presents the prediction over a valid/ready output handshake.
- It sits between the sample source (feature FIFO / test harness) and the per-dataset BNN datapath.

---
 rtl/bnn_pkg.sv | 30 +++
 rtl/bnn_argmax.sv | 26 ++
 rtl/seq_bnn_ctrl.sv | 128 ++++++++++++
 tb/tb_seq_bnn_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the sequential BNN controller.
package bnn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      L0   = 2'd1,
      L1   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int unsigned FEAT_CNT_D   = 11;
   localparam int unsigned FEAT_BITS_D  = 4;
   localparam int unsigned HIDDEN_CNT_D = 40;
   localparam int unsigned CLASS_CNT_D  = 6;

   // Index width for a counter over n items; a single item still needs one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // A class score is a popcount over the hidden layer, 0..hidden_cnt inclusive.
   function automatic int unsigned score_w(input int unsigned hidden_cnt);
      return $clog2(hidden_cnt + 1);
   endfunction

   localparam int unsigned HID_W_D   = idx_w(HIDDEN_CNT_D);
   localparam int unsigned CLS_W_D   = idx_w(CLASS_CNT_D);
   localparam int unsigned SCORE_W_D = score_w(HIDDEN_CNT_D);

endpackage

// File: rtl/bnn_argmax.sv
// Running-max tracker over class scores; ties keep the earliest index.
module bnn_argmax #(
   parameter int unsigned IDX_W   = 3,
   parameter int unsigned SCORE_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               en,
   input  logic [IDX_W-1:0]   idx,
   input  logic [SCORE_W-1:0] score,
   output logic [IDX_W-1:0]   best_idx,
   output logic [SCORE_W-1:0] best_score
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         best_idx   <= '0;
         best_score <= '0;
      end else if (en && (start || (score > best_score))) begin
         best_idx   <= idx;
         best_score <= score;
      end
   end

endmodule

// File: rtl/seq_bnn_ctrl.sv
// Sequencer for the BNN datapath: latch a vector, step layer 0 then layer 1,
// track the argmax and hand the prediction out over valid/ready.
module seq_bnn_ctrl
   import bnn_pkg::*;
#(
   parameter  int unsigned FEAT_CNT   = FEAT_CNT_D,
   parameter  int unsigned FEAT_BITS  = FEAT_BITS_D,
   parameter  int unsigned HIDDEN_CNT = HIDDEN_CNT_D,
   parameter  int unsigned CLASS_CNT  = CLASS_CNT_D,
   parameter  int unsigned SCORE_W    = score_w(HIDDEN_CNT),
   localparam int unsigned FEAT_W     = FEAT_CNT * FEAT_BITS,
   localparam int unsigned HID_W      = idx_w(HIDDEN_CNT),
   localparam int unsigned CLS_W      = idx_w(CLASS_CNT)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [FEAT_W-1:0]     features,
   output logic [FEAT_W-1:0]     feat_lat,
   output logic                  hid_en,
   output logic [HID_W-1:0]      hid_idx,
   input  logic                  hid_bit,
   output logic [HIDDEN_CNT-1:0] hidden_act,
   output logic                  cls_en,
   output logic [CLS_W-1:0]      cls_idx,
   input  logic [SCORE_W-1:0]    cls_score,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CLS_W-1:0]      prediction
);

   state_t             state;
   state_t             next_state;
   logic               hid_last;
   logic               cls_last;
   logic               accept;
   logic [CLS_W-1:0]   best_idx;
   logic [SCORE_W-1:0] best_score;

   assign hid_last = (hid_idx == HID_W'(HIDDEN_CNT - 1));
   assign cls_last = (cls_idx == CLS_W'(CLASS_CNT - 1));
   assign accept   = in_valid && in_ready;

   // Next-state logic.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept)    next_state = L0;
         L0:      if (hid_last)  next_state = L1;
         L1:      if (cls_last)  next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   // State register; handshake and step enables are registered from next_state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         hid_en    <= 1'b0;
         cls_en    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= next_state;
         in_ready  <= (next_state == IDLE);
         hid_en    <= (next_state == L0);
         cls_en    <= (next_state == L1);
         out_valid <= (next_state == DONE);
      end
   end

   // Datapath-facing registers: feature latch, activation capture, step counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         feat_lat   <= '0;
         hidden_act <= '0;
         hid_idx    <= '0;
         cls_idx    <= '0;
         prediction <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  feat_lat   <= features;
                  hidden_act <= '0;
                  hid_idx    <= '0;
               end
            end
            L0: begin
               hidden_act[hid_idx] <= hid_bit;
               if (hid_last) begin
                  hid_idx <= '0;
                  cls_idx <= '0;
               end else begin
                  hid_idx <= hid_idx + HID_W'(1);
               end
            end
            L1: begin
               if (cls_last) begin
                  cls_idx    <= '0;
                  // Fold in the last score here so prediction is final on entry to DONE.
                  prediction <= ((cls_idx == '0) || (cls_score > best_score)) ? cls_idx : best_idx;
               end else begin
                  cls_idx <= cls_idx + CLS_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   bnn_argmax #(
      .IDX_W   (CLS_W),
      .SCORE_W (SCORE_W)
   ) u_argmax (
      .clk        (clk),
      .rst        (rst),
      .start      (cls_idx == '0),
      .en         (state == L1),
      .idx        (cls_idx),
      .score      (cls_score),
      .best_idx   (best_idx),
      .best_score (best_score)
   );

endmodule

// File: tb/tb_seq_bnn_ctrl.sv
// Directed bench for seq_bnn_ctrl: default build plus a small 5-hidden/3-class build.
module tb_seq_bnn_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, hid_en, hid_bit, cls_en, out_valid, out_ready;
   logic [43:0] features, feat_lat;
   logic [5:0]  hid_idx;
   logic [39:0] hidden_act;
   logic [2:0]  cls_idx, prediction;
   logic [5:0]  cls_score;
   logic [5:0]  scores [6];

   logic        s_in_valid, s_in_ready, s_hid_en, s_hid_bit, s_cls_en, s_out_valid, s_out_ready;
   logic [43:0] s_features, s_feat_lat;
   logic [2:0]  s_hid_idx;
   logic [4:0]  s_hidden_act;
   logic [1:0]  s_cls_idx, s_prediction;
   logic [2:0]  s_cls_score;
   logic [2:0]  s_scores [3];

   int n_chk = 0;
   int n_fail = 0;
   int s_max_hid = 0;
   int s_max_cls = 0;
   logic [2:0] q[$];
   logic [1:0] sq[$];

   seq_bnn_ctrl u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .features(features), .feat_lat(feat_lat), .hid_en(hid_en), .hid_idx(hid_idx),
      .hid_bit(hid_bit), .hidden_act(hidden_act), .cls_en(cls_en), .cls_idx(cls_idx),
      .cls_score(cls_score), .out_valid(out_valid), .out_ready(out_ready),
      .prediction(prediction)
   );

   seq_bnn_ctrl #(.HIDDEN_CNT(5), .CLASS_CNT(3)) u_small (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .features(s_features), .feat_lat(s_feat_lat), .hid_en(s_hid_en), .hid_idx(s_hid_idx),
      .hid_bit(s_hid_bit), .hidden_act(s_hidden_act), .cls_en(s_cls_en), .cls_idx(s_cls_idx),
      .cls_score(s_cls_score), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .prediction(s_prediction)
   );

   // Datapath stand-in: activation is parity of the neuron index, scores from a table.
   always_comb begin
      hid_bit     = hid_idx[0];
      cls_score   = (cls_idx < 3'd6) ? scores[cls_idx] : 6'd0;
      s_hid_bit   = s_hid_idx[0];
      s_cls_score = (s_cls_idx < 2'd3) ? s_scores[s_cls_idx] : 3'd0;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Structural invariants on both instances, checked every cycle out of reset.
   always @(negedge clk) begin
      if (rst) begin
         n_chk++;
         assert (!(hid_en && cls_en) && !(in_ready && (hid_en || cls_en || out_valid))) else begin
            n_fail++;
            $error("FAIL excl observed=%b%b%b%b expected=no_overlap", in_ready, hid_en, cls_en, out_valid);
         end
         n_chk++;
         assert (!(s_hid_en && s_cls_en)) else begin
            n_fail++;
            $error("FAIL s_excl observed=%b%b expected=not_both", s_hid_en, s_cls_en);
         end
         if (int'(s_hid_idx) > s_max_hid) s_max_hid = int'(s_hid_idx);
         if (int'(s_cls_idx) > s_max_cls) s_max_cls = int'(s_cls_idx);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_scores(input logic [5:0] a, b, c, d, e, f);
      scores[0] = a; scores[1] = b; scores[2] = c;
      scores[3] = d; scores[4] = e; scores[5] = f;
   endtask

   task automatic send(input logic [43:0] f, input logic [2:0] exp);
      int k = 0;
      features = f;
      in_valid = 1'b1;
      while (!in_ready && k < 200) begin tick(); k++; end
      chk("send_ready", 64'(in_ready), 64'd1);
      q.push_back(exp);
      tick();
      in_valid = 1'b0;
      chk("l0_enter_en", 64'(hid_en), 64'd1);
      chk("l0_enter_idx", 64'(hid_idx), 64'd0);
      chk("feat_latched", 64'(feat_lat), 64'(f));
   endtask

   task automatic wait_out(input int exp_lat);
      int k = 0;
      while (!out_valid && k < 200) begin tick(); k++; end
      chk("latency", 64'(k), 64'(exp_lat));
      chk("done_no_step", 64'({hid_en, cls_en}), 64'd0);
   endtask

   task automatic consume();
      logic [2:0] exp;
      exp = (q.size() > 0) ? q.pop_front() : 3'bxxx;
      chk("prediction", 64'(prediction), 64'(exp));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_out_valid", 64'(out_valid), 64'd0);
      chk("post_in_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic s_run(input logic [2:0] a, b, c, input logic [1:0] exp);
      int k = 0;
      s_scores[0] = a; s_scores[1] = b; s_scores[2] = c;
      chk("s_in_ready", 64'(s_in_ready), 64'd1);
      s_features = 44'h0F0F0F0F0F0;
      s_in_valid = 1'b1;
      sq.push_back(exp);
      tick();
      s_in_valid = 1'b0;
      while (!s_out_valid && k < 50) begin tick(); k++; end
      chk("s_latency", 64'(k), 64'd8);
      chk("s_hidden_act", 64'(s_hidden_act), 64'h0A);
      chk("s_prediction", 64'(s_prediction), 64'(sq.pop_front()));
      s_out_ready = 1'b1;
      tick();
      s_out_ready = 1'b0;
      chk("s_post_valid", 64'(s_out_valid), 64'd0);
   endtask

   initial begin
      int k;
      logic [43:0] f, prev;
      logic [2:0]  obs;
      logic        hs, pv, seen;
      int          hs_edges[$];

      in_valid = 1'b0; out_ready = 1'b0; features = '0;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_features = '0;
      set_scores(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
      s_scores[0] = 3'd0; s_scores[1] = 3'd0; s_scores[2] = 3'd0;

      // Reset state.
      tick(); tick();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_flags", 64'({out_valid, hid_en, cls_en}), 64'd0);
      chk("rst_idx", 64'({hid_idx, cls_idx, prediction}), 64'd0);
      chk("rst_feat_lat", 64'(feat_lat), 64'd0);
      chk("rst_hidden_act", 64'(hidden_act), 64'd0);
      #3 rst = 1'b1;
      tick();

      // Single inference; tie between classes 1 and 3 resolves to 1.
      set_scores(6'd3, 6'd7, 6'd2, 6'd7, 6'd5, 6'd1);
      send(44'h123456789AB, 3'd1);
      wait_out(46);
      chk("hidden_act", 64'(hidden_act), 64'hAAAAAAAAAA);
      consume();

      // Monotonic scores, then all-equal zeros.
      set_scores(6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd40);
      send(44'h00000000001, 3'd5);
      wait_out(46);
      consume();
      set_scores(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0);
      send(44'h00000000002, 3'd0);
      wait_out(46);
      consume();

      // Backpressure in DONE with a second vector waiting.
      set_scores(6'd1, 6'd2, 6'd9, 6'd3, 6'd4, 6'd5);
      send(44'hAAAA5555AAA, 3'd2);
      wait_out(46);
      features = 44'h0BBBBBBBBBB;
      in_valid = 1'b1;
      repeat (20) begin
         tick();
         chk("bp_hold", 64'({out_valid, in_ready, prediction}), 64'({1'b1, 1'b0, 3'd2}));
         chk("bp_feat_lat", 64'(feat_lat), 64'hAAAA5555AAA);
      end
      chk("bp_prediction", 64'(prediction), 64'(q.pop_front()));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_idle", 64'({out_valid, in_ready}), 64'b01);
      chk("bp_not_early", 64'(feat_lat), 64'hAAAA5555AAA);
      q.push_back(3'd2);
      tick();
      in_valid = 1'b0;
      chk("bp_accept", 64'(feat_lat), 64'h0BBBBBBBBBB);
      chk("bp_accept_en", 64'(hid_en), 64'd1);
      wait_out(46);
      consume();

      // Back-to-back with both handshakes held high.
      set_scores(6'd3, 6'd7, 6'd2, 6'd7, 6'd5, 6'd1);
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 150; i++) begin
         hs = in_ready && in_valid;
         pv = out_valid && out_ready;
         obs = prediction;
         prev = feat_lat;
         f = 44'({$urandom(), $urandom()});
         features = f;
         tick();
         if (pv) chk("b2b_pred", 64'(obs), 64'((q.size() > 0) ? q.pop_front() : 3'bxxx));
         if (hs) begin
            hs_edges.push_back(i);
            q.push_back(3'd1);
            chk("b2b_latch", 64'(feat_lat), 64'(f));
         end else begin
            chk("b2b_hold", 64'(feat_lat), 64'(prev));
         end
      end
      in_valid = 1'b0;
      chk("b2b_hs_count", 64'(hs_edges.size()), 64'd4);
      for (int i = 1; i < hs_edges.size(); i++)
         chk("b2b_gap", 64'(hs_edges[i] - hs_edges[i-1]), 64'd48);
      k = 0;
      while (q.size() > 0 && k < 200) begin
         pv = out_valid && out_ready;
         obs = prediction;
         tick();
         if (pv) chk("drain_pred", 64'(obs), 64'(q.pop_front()));
         k++;
      end
      chk("drain_empty", 64'(q.size()), 64'd0);
      out_ready = 1'b0;

      // Asynchronous reset pulse in the middle of layer 1.
      set_scores(6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6);
      send(44'h13579BDF024, 3'd5);
      k = 0;
      while (!(cls_en && cls_idx == 3'd3) && k < 200) begin tick(); k++; end
      chk("mid_l1_reached", 64'({cls_en, cls_idx}), 64'({1'b1, 3'd3}));
      #2 rst = 1'b0;
      #1;
      chk("arst_ready", 64'(in_ready), 64'd1);
      chk("arst_flags", 64'({out_valid, hid_en, cls_en}), 64'd0);
      chk("arst_idx", 64'({hid_idx, cls_idx, prediction}), 64'd0);
      chk("arst_data", 64'(feat_lat | 44'(hidden_act)), 64'd0);
      q.delete();
      #10 rst = 1'b1;
      tick();
      seen = 1'b0;
      repeat (60) begin tick(); seen = seen | out_valid; end
      chk("arst_no_valid", 64'(seen), 64'd0);
      chk("arst_idle", 64'(in_ready), 64'd1);
      set_scores(6'd9, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6);
      send(44'h2468ACE1357, 3'd0);
      wait_out(46);
      consume();

      // Small build: five hidden neurons, three classes.
      s_run(3'd2, 3'd4, 3'd4, 2'd1);
      s_run(3'd1, 3'd3, 3'd7, 2'd2);
      chk("s_max_hid", 64'(s_max_hid), 64'd4);
      chk("s_max_cls", 64'(s_max_cls), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
